// File: rtl/sub_pkg.sv
// Shared types and default sizing for the chunked serial subtractor.
// The FSM state encoding lives here so the bench and any wrappers see the same names.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;

endpackage : sub_pkg

// File: rtl/sub_chunk.sv
// CHUNK-bit combinational ripple subtractor: d = x - y - bin, bout = borrow out of the top bit.
// Built from per-bit half-subtractor terms so the borrow chain stays explicit.
module sub_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             bin,
   output logic [CHUNK-1:0] d,
   output logic             bout
);

   logic [CHUNK:0] brw;

   assign brw[0] = bin;

   genvar gi;
   generate
      for (gi = 0; gi < CHUNK; gi++) begin : g_bit
         assign d[gi]       = x[gi] ^ y[gi] ^ brw[gi];
         assign brw[gi + 1] = (~x[gi] & y[gi]) | (~(x[gi] ^ y[gi]) & brw[gi]);
      end
   endgenerate

   assign bout = brw[CHUNK];

endmodule : sub_chunk

// File: rtl/serial_sub.sv
// Serial subtractor: captures a/b once, then subtracts CHUNK bits per clock, LSB chunk first,
// and holds diff/borrow/ovf in DONE until the consumer takes them.
module serial_sub
   import sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   input  logic             signed_mode,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   generate
      if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_width
         $error("serial_sub: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   state_t            state_reg, state_next;
   logic [IDXW-1:0]   idx_reg,   idx_next;
   logic [WIDTH-1:0]  a_reg,     a_next;
   logic [WIDTH-1:0]  b_reg,     b_next;
   logic              smode_reg, smode_next;
   logic              brw_reg,   brw_next;
   logic [WIDTH-1:0]  diff_reg,  diff_next;
   logic              ovf_reg,   ovf_next;

   logic [CHUNK-1:0]  cur_a, cur_b, cur_d;
   logic              cur_bout;
   logic              last_chunk;

   // Route the active chunk of each captured operand into the shared chunk subtractor.
   always_comb begin
      cur_a = '0;
      cur_b = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx_reg == IDXW'(i)) begin
            cur_a = a_reg[i*CHUNK +: CHUNK];
            cur_b = b_reg[i*CHUNK +: CHUNK];
         end
      end
   end

   sub_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .x    (cur_a),
      .y    (cur_b),
      .bin  (brw_reg),
      .d    (cur_d),
      .bout (cur_bout)
   );

   assign last_chunk = (idx_reg == IDXW'(NCHUNK - 1));

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      smode_next = smode_reg;
      brw_next   = brw_reg;
      diff_next  = diff_reg;
      ovf_next   = ovf_reg;

      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               a_next     = a;
               b_next     = b;
               smode_next = signed_mode;
               brw_next   = borrow_in;
               idx_next   = '0;
               ovf_next   = 1'b0;
               state_next = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < NCHUNK; i++) begin
               if (idx_reg == IDXW'(i)) begin
                  diff_next[i*CHUNK +: CHUNK] = cur_d;
               end
            end
            brw_next = cur_bout;
            if (last_chunk) begin
               // The last chunk carries the MSB, so cur_d's top bit is the final diff sign.
               ovf_next   = smode_reg & (a_reg[WIDTH-1] != b_reg[WIDTH-1])
                                      & (cur_d[CHUNK-1] != a_reg[WIDTH-1]);
               idx_next   = '0;
               state_next = DONE;
            end else begin
               idx_next = idx_reg + IDXW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         smode_reg <= 1'b0;
         brw_reg   <= 1'b0;
         diff_reg  <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         smode_reg <= smode_next;
         brw_reg   <= brw_next;
         diff_reg  <= diff_next;
         ovf_reg   <= ovf_next;
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign diff      = diff_reg;
   assign borrow    = brw_reg;
   assign ovf       = ovf_reg;

endmodule : serial_sub

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub at WIDTH=16, CHUNK=4 with hand-computed expected results.
// Outputs are sampled 1 time unit after the rising edge or mid-cycle.
module tb_serial_sub;

   localparam int WIDTH = 16;
   localparam int CHUNK = 4;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             borrow_in;
   logic             signed_mode;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             ovf;
   logic             out_valid;
   logic             out_ready;

   int checks;
   int errors;

   serial_sub #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a           (a),
      .b           (b),
      .borrow_in   (borrow_in),
      .signed_mode (signed_mode),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .diff        (diff),
      .borrow      (borrow),
      .ovf         (ovf),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Present one operation, check the NCHUNK-edge latency, the results, then consume them.
   task automatic run_op(input string tag,
                         input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic bi, input logic sm,
                         input logic [WIDTH-1:0] ed, input logic eb, input logic eo,
                         input logic consume);
      @(negedge clk);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      a = av; b = bv; borrow_in = bi; signed_mode = sm; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int k = 1; k <= WIDTH / CHUNK; k++) begin
         if (k > 1) begin
            @(posedge clk);
            #1;
         end
         if (k < WIDTH / CHUNK) begin
            chk({tag, ".out_valid_early"}, 32'(out_valid), 32'd0);
         end
      end
      @(posedge clk);
      #1;
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".diff"},      32'(diff),      32'(ed));
      chk({tag, ".borrow"},    32'(borrow),    32'(eb));
      chk({tag, ".ovf"},       32'(ovf),       32'(eo));
      $display("op %s a=%04h b=%04h bin=%0d sm=%0d -> diff=%04h borrow=%0d ovf=%0d",
               tag, av, bv, bi, sm, diff, borrow, ovf);
      if (consume) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
         chk({tag, ".idle_in_ready"}, 32'(in_ready),  32'd1);
         chk({tag, ".idle_out_valid"}, 32'(out_valid), 32'd0);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      a = '0; b = '0; borrow_in = 1'b0; signed_mode = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("reset.in_ready",  32'(in_ready),  32'd1);
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.diff",      32'(diff),      32'd0);
      chk("reset.borrow",    32'(borrow),    32'd0);
      chk("reset.ovf",       32'(ovf),       32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("basic",     16'h1234, 16'h0234, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
      run_op("wrap",      16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
      run_op("sovf",      16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b1);
      run_op("uovf",      16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
      run_op("bin",       16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1);
      run_op("s_noovf",   16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1);
      run_op("bin_wrap",  16'h0003, 16'h0003, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);

      // Backpressure: result held, new operands ignored while DONE.
      run_op("bp",        16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 16'h9696, 1'b0, 1'b0, 1'b0);
      a = 16'h0001; b = 16'h0002; borrow_in = 1'b1; in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk("bp.out_valid", 32'(out_valid), 32'd1);
         chk("bp.diff",      32'(diff),      32'h9696);
         chk("bp.in_ready",  32'(in_ready),  32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp.release_in_ready",  32'(in_ready),  32'd1);
      chk("bp.release_out_valid", 32'(out_valid), 32'd0);
      $display("op bp_release in_ready=%0d out_valid=%0d", in_ready, out_valid);

      // Mid-run reset after two RUN edges, then a fresh operation.
      @(negedge clk);
      a = 16'h1234; b = 16'h0111; borrow_in = 1'b0; signed_mode = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mrst.diff",      32'(diff),      32'd0);
      chk("mrst.borrow",    32'(borrow),    32'd0);
      chk("mrst.ovf",       32'(ovf),       32'd0);
      chk("mrst.out_valid", 32'(out_valid), 32'd0);
      chk("mrst.in_ready",  32'(in_ready),  32'd1);
      $display("op mid_reset diff=%04h in_ready=%0d out_valid=%0d", diff, in_ready, out_valid);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst",  16'h0010, 16'h0001, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_serial_sub

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits subtracted per RUN cycle.
- WIDTH must be a positive multiple of CHUNK.
- NCHUNK = WIDTH/CHUNK.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have the following data and handshake ports:
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- borrow_in  input  1  initial borrow into chunk 0.
- signed_mode  input  1  1 means the operands are two's complement, so ovf is meaningful.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH.
- borrow  output  1  borrow out of the MSB.
- ovf  output  1  signed overflow, 0 when signed_mode=0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.

Function
REQ-005 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-006 In IDLE, in_ready SHALL be 1; in_valid&&in_ready at an edge SHALL capture a, b, borrow_in and signed_mode, clear the chunk index to 0, and go to RUN.
REQ-007 In RUN, each edge SHALL subtract chunk[idx] of the captured b from chunk[idx] of the captured a using the stored borrow, write chunk[idx] of diff, update the stored borrow, and increment idx.
REQ-008 The chunk processed at idx = NCHUNK-1 SHALL move the FSM to DONE; out_valid SHALL rise exactly NCHUNK edges after the accepting edge.
REQ-009 In DONE, out_valid SHALL be 1, and diff, borrow and ovf SHALL be held stable until out_valid&&out_ready at an edge, which returns the FSM to IDLE.
REQ-010 in_ready SHALL be 1 only in IDLE; in_valid is ignored in RUN and DONE, and captured operands SHALL NOT change when the inputs change mid-operation.
REQ-011 borrow SHALL equal the borrow out of the MSB chunk, i.e. 1 exactly when unsigned a < b + borrow_in.
REQ-012 ovf SHALL equal signed_mode & (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), computed from the captured operands in the final RUN cycle.
REQ-013 While not in DONE, out_valid SHALL be 0; diff may show partial results and SHALL NOT be consumed.
REQ-014 The WIDTH == CHUNK case SHALL give a single RUN cycle with identical semantics.
REQ-015 All arithmetic SHALL be unsigned modulo 2^WIDTH with no sign extension; the result is wrap-around, never saturation.

Reset
REQ-016 Assertion of rst_n=0 SHALL immediately, without a clock, force:
- state to IDLE, chunk index to 0, stored borrow to 0;
- diff=0, borrow=0, ovf=0, out_valid=0, in_ready=1.
REQ-017 A reset during RUN or DONE SHALL abandon the operation with no output handshake; operation resumes at the first rising edge after rst_n=1.

Structure
REQ-018 A shared package sub_pkg SHALL hold:
- the state typedef (IDLE/RUN/DONE);
- default WIDTH/CHUNK constants.
REQ-019 A combinational sub-module sub_chunk SHALL provide the CHUNK-bit ripple subtract:
- inputs: x, y, bin;
- outputs: d, bout;
- each bit uses half-subtractor terms: d = x^y^bin, bout = (~x&y)|(~(x^y)&bin).
REQ-020 An elaboration-time check SHALL fail when WIDTH%CHUNK != 0.

Verification
REQ-021 The bench (WIDTH=16, CHUNK=4) SHALL cover these directed scenarios:
- Basic subtract: a=0x1234, b=0x0234, borrow_in=0, in_valid=1 -> after 4 edges out_valid=1, diff=0x1000, borrow=0, ovf=0.
- Unsigned wrap: a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1.
- Signed overflow: signed_mode=1, a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1; the same operands with signed_mode=0 -> ovf=0.
- Borrow in: a=0x0005, b=0x0003, borrow_in=1 -> diff=0x0001, borrow=0.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and diff held, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE and in_ready=1 next cycle.
- Mid-run reset: pulse rst_n=0 after 2 RUN edges -> outputs immediately 0, in_ready=1; the next operation 0x0010-0x0001 -> 0x000F.
